param_fifo: RTL
===============

# param_fifo

Parametrised synchronous FIFO replacing the fixed 16-bit × 128 DTW sample buffer. It is generic in width, depth and thresholds, and selects show-ahead or registered-output read mode. It has exact occupancy counting: full and empty are unambiguous at every depth. It also provides programmable almost-empty/almost-full flags and sticky overflow/underflow error flags. It sits between processor I/O ports and streaming datapaths (DTW, filters) in the same single clock domain.

## Interface
- WIDTH, 16: data width in bits; data is signed two's complement.
- DEPTH, 128: number of entries; must be a power of two, ≥ 4.
- AE_TH, 2: almost_empty asserts while usedw < AE_TH.
- AF_TH, DEPTH-2: almost_full asserts while usedw ≥ AF_TH.
- SHOWAHEAD, 1: 1 = q presents the head word combinationally; 0 = q is registered and updated one cycle after a read.
- Derived AW = $clog2(DEPTH).

Ports:
- clock  in  1  single clock, all logic on rising edge.
- sclr  in  1  reset; synchronous, active-high.
- data  in  WIDTH  signed write data.
- wrreq  in  1  write request.
- rdreq  in  1  read request.
- q  out  WIDTH  signed read data.
- usedw  out  AW+1  occupancy, 0..DEPTH.
- empty  out  1  usedw == 0.
- full  out  1  usedw == DEPTH.
- almost_empty  out  1  usedw < AE_TH.
- almost_full  out  1  usedw ≥ AF_TH.
- overflow  out  1  sticky; a write was refused.
- underflow  out  1  sticky; a read was refused.

## Operation
- Internal state: wr_ptr and rd_ptr are AW bits each and wrap modulo DEPTH naturally; count is AW+1 bits; q_reg exists only when SHOWAHEAD=0.
- rd_ok = rdreq & !empty.
- wr_ok = wrreq & (!full | rd_ok). A write into a full FIFO is accepted when a read is accepted in the same cycle.
- wr_ok: mem[wr_ptr] ← data, wr_ptr++.
- rd_ok: rd_ptr++.
- count: +1 on wr_ok only, −1 on rd_ok only, unchanged when both or neither occur.
- Write and read requests are taken in the same cycle they are asserted. There is no input delay stage.
- All flags are decoded combinationally from count; usedw = count.
- SHOWAHEAD=1: q = empty ? 0 : mem[rd_ptr]. rdreq acknowledges the word currently on q.
- SHOWAHEAD=0: on rd_ok, q_reg ← mem[rd_ptr]; otherwise q_reg holds its value.
- On an empty FIFO, a write and a read in the same cycle: the read is refused (rd_ok = 0) and the write is accepted.
- overflow sets on wrreq & full & !rd_ok.
- underflow sets on rdreq & empty.
- Both error flags clear only on sclr.
- Refused operations change no pointer, no count and no memory.

## Timing
- sclr (sync): next edge gives pointers 0, count 0, q_reg 0, overflow 0, underflow 0.
- Reset output values: empty=1, full=0, usedw=0, almost_empty=1 (for AE_TH>0), almost_full=0, q=0.
- Memory contents are not cleared.
- sclr has priority over simultaneous wrreq/rdreq. A transfer in progress is discarded.
- Write latency: a word written at edge N is visible on q (SHOWAHEAD=1, previously empty) after edge N, with empty=0 in cycle N+1.
- Read latency: SHOWAHEAD=1 gives 0 cycles, the next word appears after the rd_ok edge. SHOWAHEAD=0 gives 1 cycle, q_reg is valid after the rd_ok edge.
- Flags reflect count after each edge. There is no lookahead and no registered flag lag.
- Throughput is one write and one read per cycle, sustained.

## Structure
- Shared package sapho_fifo_pkg holds the parameter validity check function (power of two, AE_TH ≤ AF_TH ≤ DEPTH) and the default WIDTH/DEPTH constants reused by DTW blocks.
- One sub-module, fifo_ram: simple dual-port array, synchronous write, asynchronous read, parameters WIDTH and DEPTH. The top level holds pointers, count, flags and output mode.

## Test plan
All scenarios use WIDTH=16, DEPTH=8, AE_TH=2, AF_TH=6.
- Reset then idle: empty=1, almost_empty=1, usedw=0, q=0, full=0, overflow=0, underflow=0.
- Fill then drain:
  - Write 8 words −4..3: full=1 and usedw=8 after the 8th edge; almost_full rose at usedw=6.
  - Read 8: q sequence −4..3 in order (SHOWAHEAD=1 same cycle; SHOWAHEAD=0 one cycle late); empty=1 at the end.
- Overflow/underflow:
  - 9th write while full and no read: overflow=1, usedw stays 8, word 0 unchanged.
  - rdreq while empty: underflow=1.
  - Both flags hold until sclr.
- Simultaneous read/write:
  - At full: usedw stays 8 and the new word lands after the oldest ones.
  - At empty: read refused, usedw becomes 1, underflow=1.
- Wrap-around: 20 interleaved write/read pairs at occupancy 3 keep usedw=3 and output data in order across pointer wrap.
- Reset mid-operation: sclr with usedw=5 and wrreq=1 gives usedw=0 and empty=1 next cycle, with the write discarded.

Source files
------------

// File: rtl/sapho_fifo_pkg.sv
// Shared FIFO definitions: default DTW buffer geometry and the parameter sanity check
// used by every FIFO instance in the streaming datapaths.
package sapho_fifo_pkg;

  localparam int DTW_WIDTH = 16;
  localparam int DTW_DEPTH = 128;

  // Depth must be a power of two (pointers wrap for free) and thresholds must be ordered.
  function automatic bit fifo_params_valid(input int depth, input int ae_th, input int af_th);
    return (depth >= 4) && ((depth & (depth - 1)) == 0) &&
           (ae_th >= 0) && (ae_th <= af_th) && (af_th <= depth);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage array: synchronous write, asynchronous read.
module fifo_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 128,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/param_fifo.sv
// Parametrised single-clock FIFO with exact occupancy count, threshold flags,
// sticky error flags and selectable show-ahead or registered read data.
module param_fifo
  import sapho_fifo_pkg::*;
#(
  parameter int WIDTH     = DTW_WIDTH,
  parameter int DEPTH     = DTW_DEPTH,
  parameter int AE_TH     = 2,
  parameter int AF_TH     = DEPTH - 2,
  parameter int SHOWAHEAD = 1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                    clock,
  input  logic                    sclr,
  input  logic signed [WIDTH-1:0] data,
  input  logic                    wrreq,
  input  logic                    rdreq,
  output logic signed [WIDTH-1:0] q,
  output logic [AW:0]             usedw,
  output logic                    empty,
  output logic                    full,
  output logic                    almost_empty,
  output logic                    almost_full,
  output logic                    overflow,
  output logic                    underflow
);

  localparam bit PARAMS_OK = fifo_params_valid(DEPTH, AE_TH, AF_TH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [AW:0] AE_C    = (AW + 1)'(AE_TH);
  localparam logic [AW:0] AF_C    = (AW + 1)'(AF_TH);

  if (!PARAMS_OK) begin : g_bad_params
    $error("param_fifo: DEPTH must be a power of two >= 4 and AE_TH <= AF_TH <= DEPTH");
  end

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             rd_ok, wr_ok;
  logic [WIDTH-1:0] rd_word;

  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_C);
  assign almost_empty = (count_q < AE_C);
  assign almost_full  = (count_q >= AF_C);
  assign usedw        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A full FIFO still accepts a write when a read frees a slot in the same cycle.
  always_comb begin
    rd_ok       = rdreq && !empty;
    wr_ok       = wrreq && (!full || rd_ok);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q || (wrreq && full && !rd_ok);
    underflow_d = underflow_q || (rdreq && empty);
    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (sclr) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Reset wins over a simultaneous write, so the store is gated as well.
  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clock   (clock),
    .wr_en   (wr_ok && !sclr),
    .wr_addr (wr_ptr_q),
    .wr_data (data),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_word)
  );

  if (SHOWAHEAD != 0) begin : g_showahead
    assign q = empty ? '0 : rd_word;
  end else begin : g_registered
    logic [WIDTH-1:0] q_reg_q, q_reg_d;

    always_comb begin
      q_reg_d = q_reg_q;
      if (rd_ok) begin
        q_reg_d = rd_word;
      end
    end

    always_ff @(posedge clock) begin
      if (sclr) begin
        q_reg_q <= '0;
      end else begin
        q_reg_q <= q_reg_d;
      end
    end

    assign q = q_reg_q;
  end

endmodule
